// File: rtl/instr_ctrl_pkg.sv
// Shared constants for the instruction controller: state encodings, opcodes,
// PC source codes, instruction field positions and ALU status bit indices.
package instr_ctrl_pkg;

    typedef enum logic [2:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_e;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_RR = 4'h1;
    localparam logic [3:0] OP_ALU_RI = 4'h2;
    localparam logic [3:0] OP_BRA    = 4'h4;
    localparam logic [3:0] OP_BRR    = 4'h5;
    localparam logic [3:0] OP_LOD    = 4'h8;
    localparam logic [3:0] OP_STR    = 4'h9;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [1:0] PC_SEL_INC = 2'd0;
    localparam logic [1:0] PC_SEL_ABS = 2'd1;
    localparam logic [1:0] PC_SEL_REL = 2'd2;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int MM_MSB  = 27;
    localparam int MM_LSB  = 24;
    localparam int RD_MSB  = 23;
    localparam int RD_LSB  = 20;
    localparam int RS_MSB  = 19;
    localparam int RS_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 12;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam int STAT_C = 3;
    localparam int STAT_V = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

    function automatic logic is_branch(input logic [3:0] opcode);
        return (opcode == OP_BRA) || (opcode == OP_BRR);
    endfunction

endpackage

// File: rtl/instr_ctrl_br_cond.sv
// Branch-taken flag: a branch with an empty mask is unconditional, otherwise
// it is taken when any masked ALU status bit is set.
module br_cond
    import instr_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       taken
);

    logic cond_hit;

    assign cond_hit = (mm[STAT_C] & stat[STAT_C]) |
                      (mm[STAT_V] & stat[STAT_V]) |
                      (mm[STAT_N] & stat[STAT_N]) |
                      (mm[STAT_Z] & stat[STAT_Z]);

    assign taken = is_branch(opcode) & ((mm == 4'd0) | cond_hit);

endmodule

// File: rtl/instr_ctrl.sv
// Multi-cycle instruction sequencer; the state register is the only flop and
// all datapath controls decode combinationally from state and instruction.
//
// state     | meaning
// START0    | first cycle after reset, everything idle
// START1    | second idle cycle, lets the datapath settle
// FETCH     | load IR, advance PC
// DECODE    | resolve branches, pick the execution path
// EXECUTE   | ALU operation on latched operands
// MEM       | data-memory access (store writes here)
// WRITEBACK | register-file write
// HALT      | parked until reset
module instr_ctrl
    import instr_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_f,
    input  logic [31:0] instr,
    input  logic [3:0]  stat,
    output logic [3:0]  read_rega,
    output logic [3:0]  read_regb,
    output logic [3:0]  write_reg,
    output logic        rf_we,
    output logic [3:0]  alu_op,
    output logic        alu_imm,
    output logic        stat_en,
    output logic        ir_load,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        mem_we,
    output logic        wb_sel,
    output logic [2:0]  state
);

    state_e     state_q, state_d;
    logic [3:0] opcode, mm, rd, rs, rt;
    logic       br_taken;
    logic       unused_imm;

    assign opcode     = instr[OPC_MSB:OPC_LSB];
    assign mm         = instr[MM_MSB:MM_LSB];
    assign rd         = instr[RD_MSB:RD_LSB];
    assign rs         = instr[RS_MSB:RS_LSB];
    assign rt         = instr[RT_MSB:RT_LSB];
    assign unused_imm = ^instr[IMM_MSB:IMM_LSB];

    br_cond u_br_cond (
        .opcode (opcode),
        .mm     (mm),
        .stat   (stat),
        .taken  (br_taken)
    );

    // Stores read the data register through port B, so rd replaces rt there.
    assign read_rega = rs;
    assign read_regb = (opcode == OP_STR) ? rd : rt;
    assign write_reg = rd;
    assign state     = state_q;

    always_comb begin
        state_d  = state_q;
        rf_we    = 1'b0;
        alu_op   = 4'd0;
        alu_imm  = 1'b0;
        stat_en  = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = PC_SEL_INC;
        mem_we   = 1'b0;
        wb_sel   = 1'b0;

        case (state_q)
            S_START0: state_d = S_START1;
            S_START1: state_d = S_FETCH;
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                pc_sel   = PC_SEL_INC;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (br_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = (opcode == OP_BRA) ? PC_SEL_ABS : PC_SEL_REL;
                end
                case (opcode)
                    OP_ALU_RR, OP_ALU_RI, OP_LOD, OP_STR: state_d = S_EXECUTE;
                    OP_HLT:                               state_d = S_HALT;
                    OP_NOP, OP_BRA, OP_BRR:               state_d = S_FETCH;
                    default:                              state_d = S_FETCH;
                endcase
            end
            S_EXECUTE: begin
                alu_op  = mm;
                alu_imm = (opcode == OP_ALU_RI) || (opcode == OP_LOD) || (opcode == OP_STR);
                stat_en = (opcode == OP_ALU_RR) || (opcode == OP_ALU_RI);
                state_d = ((opcode == OP_LOD) || (opcode == OP_STR)) ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
                mem_we  = (opcode == OP_STR);
                state_d = (opcode == OP_LOD) ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK: begin
                wb_sel  = (opcode == OP_LOD);
                rf_we   = (rd != 4'd0);
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_START0;
        endcase

        // An instruction cut short by reset must not commit any side effect.
        if (!rst_f) begin
            rf_we    = 1'b0;
            mem_we   = 1'b0;
            pc_write = 1'b0;
            ir_load  = 1'b0;
            stat_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_f) state_q <= S_START0;
        else        state_q <= state_d;
    end

endmodule

// File: tb/tb_instr_ctrl.sv
// Bench for instr_ctrl: directed scenarios plus random instructions, checked
// per cycle against a phase-path reference model of the instruction set.
module tb_instr_ctrl;
    import instr_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [31:0] instr;
    logic [3:0]  stat;
    logic [3:0]  read_rega, read_regb, write_reg, alu_op;
    logic        rf_we, alu_imm, stat_en, ir_load, pc_write, mem_we, wb_sel;
    logic [1:0]  pc_sel;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;
    logic [27:0] hist [8];

    instr_ctrl dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .instr     (instr),
        .stat      (stat),
        .read_rega (read_rega),
        .read_regb (read_regb),
        .write_reg (write_reg),
        .rf_we     (rf_we),
        .alu_op    (alu_op),
        .alu_imm   (alu_imm),
        .stat_en   (stat_en),
        .ir_load   (ir_load),
        .pc_write  (pc_write),
        .pc_sel    (pc_sel),
        .mem_we    (mem_we),
        .wb_sel    (wb_sel),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Bundle layout: rega[27:24] regb[23:20] wreg[19:16] rf_we[15] alu_op[14:11]
    // alu_imm[10] stat_en[9] ir_load[8] pc_write[7] pc_sel[6:5] mem_we[4] wb_sel[3] state[2:0]
    function automatic logic [27:0] dut_vec();
        return {read_rega, read_regb, write_reg, rf_we, alu_op, alu_imm, stat_en,
                ir_load, pc_write, pc_sel, mem_we, wb_sel, state};
    endfunction

    function automatic logic [27:0] model(input logic [2:0] ph, input logic [31:0] ins,
                                          input logic [3:0] st, input logic rst);
        logic [3:0] op, mm, rd, rs, rt, b, aop;
        logic       rfwe, aimm, sten, irl, pcw, mwe, wbs;
        logic [1:0] pcs;
        op = ins[31:28]; mm = ins[27:24]; rd = ins[23:20]; rs = ins[19:16]; rt = ins[15:12];
        b = (op == 4'h9) ? rd : rt;
        rfwe = 0; aop = 0; aimm = 0; sten = 0; irl = 0; pcw = 0; pcs = 0; mwe = 0; wbs = 0;
        if (ph == S_FETCH) begin
            irl = 1; pcw = 1;
        end else if (ph == S_DECODE) begin
            if ((op == 4'h4 || op == 4'h5) && (mm == 0 || (mm & st) != 0)) begin
                pcw = 1;
                pcs = (op == 4'h4) ? 2'd1 : 2'd2;
            end
        end else if (ph == S_EXECUTE) begin
            aop  = mm;
            aimm = (op == 4'h2 || op == 4'h8 || op == 4'h9);
            sten = (op == 4'h1 || op == 4'h2);
        end else if (ph == S_MEM) begin
            mwe = (op == 4'h9);
        end else if (ph == S_WRITEBACK) begin
            wbs  = (op == 4'h8);
            rfwe = (rd != 0);
        end
        if (!rst) begin
            rfwe = 0; mwe = 0; pcw = 0; irl = 0; sten = 0;
        end
        return {rs, b, rd, rfwe, aop, aimm, sten, irl, pcw, pcs, mwe, wbs, ph};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_phase(input string tag, input logic [2:0] ph);
        #1;
        chk(tag, {4'd0, dut_vec()}, {4'd0, model(ph, instr, stat, rst_f)});
        hist[ph] = dut_vec();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one instruction starting in FETCH; the path follows the ISA latency rules.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] st, input string tag);
        logic [2:0] path[$];
        logic [3:0] op;
        op = ins[31:28];
        path = {S_FETCH, S_DECODE};
        if (op == 4'h1 || op == 4'h2) begin
            path.push_back(S_EXECUTE); path.push_back(S_WRITEBACK);
        end else if (op == 4'h8) begin
            path.push_back(S_EXECUTE); path.push_back(S_MEM); path.push_back(S_WRITEBACK);
        end else if (op == 4'h9) begin
            path.push_back(S_EXECUTE); path.push_back(S_MEM);
        end
        instr = ins;
        stat  = st;
        foreach (path[i]) begin
            check_phase(tag, path[i]);
            step();
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  op;

        rst_f = 1'b0; instr = 32'h0; stat = 4'h0;
        step(); step();
        check_phase("reset_start0", S_START0);
        chk("state_after_reset", {29'd0, state}, {29'd0, S_START0});
        rst_f = 1'b1;
        check_phase("idle_start0", S_START0);
        step();
        check_phase("idle_start1", S_START1);
        step();

        run_instr(32'h1532_0000, 4'b0000, "alu_rr");
        chk("alu_rr_alu_op",  {28'd0, hist[S_EXECUTE][14:11]}, 32'd5);
        chk("alu_rr_stat_en", {31'd0, hist[S_EXECUTE][9]}, 32'd1);
        chk("alu_rr_rega",    {28'd0, hist[S_EXECUTE][27:24]}, 32'd2);
        chk("alu_rr_regb",    {28'd0, hist[S_EXECUTE][23:20]}, 32'd0);
        chk("alu_rr_rf_we",   {31'd0, hist[S_WRITEBACK][15]}, 32'd1);
        chk("alu_rr_wreg",    {28'd0, hist[S_WRITEBACK][19:16]}, 32'd3);

        run_instr(32'h4400_0010, 4'b0100, "bra_taken");
        chk("bra_taken_pc_write", {31'd0, hist[S_DECODE][7]}, 32'd1);
        chk("bra_taken_pc_sel",   {30'd0, hist[S_DECODE][6:5]}, 32'd1);
        run_instr(32'h4400_0010, 4'b0001, "bra_not_taken");
        chk("bra_not_taken_pc_write", {31'd0, hist[S_DECODE][7]}, 32'd0);
        run_instr(32'h5000_0003, 4'b0000, "brr_uncond");
        chk("brr_pc_sel", {30'd0, hist[S_DECODE][6:5]}, 32'd2);

        run_instr(32'h8070_0004, 4'b0000, "lod");
        chk("lod_alu_imm", {31'd0, hist[S_EXECUTE][10]}, 32'd1);
        chk("lod_mem_we",  {31'd0, hist[S_MEM][4]}, 32'd0);
        chk("lod_wb_sel",  {31'd0, hist[S_WRITEBACK][3]}, 32'd1);
        chk("lod_rf_we",   {31'd0, hist[S_WRITEBACK][15]}, 32'd1);
        chk("lod_wreg",    {28'd0, hist[S_WRITEBACK][19:16]}, 32'd7);

        run_instr(32'h1100_0000, 4'b0000, "alu_rd0");
        chk("alu_rd0_rf_we", {31'd0, hist[S_WRITEBACK][15]}, 32'd0);
        run_instr(32'h9060_0002, 4'b0000, "str");
        chk("str_mem_we", {31'd0, hist[S_MEM][4]}, 32'd1);
        chk("str_regb",   {28'd0, hist[S_MEM][23:20]}, 32'd6);

        for (int i = 0; i < 80; i++) begin
            r  = $urandom();
            op = 4'($urandom_range(0, 14));
            run_instr({op, r[27:0]}, 4'($urandom_range(0, 15)), "random");
        end

        instr = 32'h1532_0000; stat = 4'h0;
        check_phase("rst_alu_fetch", S_FETCH);   step();
        check_phase("rst_alu_decode", S_DECODE); step();
        check_phase("rst_alu_exec", S_EXECUTE);  step();
        rst_f = 1'b0;
        check_phase("rst_in_writeback", S_WRITEBACK);
        chk("rst_in_wb_rf_we", {31'd0, rf_we}, 32'd0);
        step();
        check_phase("rst_wb_to_start0", S_START0);
        rst_f = 1'b1;
        step();
        check_phase("rst_wb_start1", S_START1);
        step();

        run_instr(32'hF000_0000, 4'b0000, "hlt");
        for (int i = 0; i < 10; i++) begin
            check_phase("halt_hold", S_HALT);
            step();
        end
        rst_f = 1'b0;
        step();
        check_phase("halt_reset", S_START0);
        rst_f = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_ctrl.md
INSTR_CTRL -- requirements
Module: instr_ctrl

Interface
REQ-001 Parameters: none; opcode, state and field positions are fixed constants in the shared package.
REQ-002 clk  input  1  single processor clock; all state changes on posedge.
REQ-003 rst_f  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 instr  input  32  current instruction-register contents: [31:28] opcode, [27:24] mm, [23:20] rd, [19:16] rs, [15:12] rt, [15:0] imm.
REQ-005 stat  input  4  ALU status {C,V,N,Z} = stat[3:0].
REQ-006 read_rega  output  4  register-file A read address.
REQ-007 read_regb  output  4  register-file B read address.
REQ-008 write_reg  output  4  register-file write address.
REQ-009 rf_we  output  1  register-file write enable.
REQ-010 alu_op  output  4  ALU function select.
REQ-011 alu_imm  output  1  1 = ALU B operand is sign-extended imm.
REQ-012 stat_en  output  1  status-register load enable.
REQ-013 ir_load  output  1  instruction-register load.
REQ-014 pc_write  output  1  PC load enable.
REQ-015 pc_sel  output  2  PC source: 0 = PC+1, 1 = imm absolute, 2 = PC+imm.
REQ-016 mem_we  output  1  data-memory write enable.
REQ-017 wb_sel  output  1  write-back source: 0 = ALU, 1 = memory.
REQ-018 state  output  3  current state, for debug.

Function
REQ-019 States: START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT; state is the only register; all other outputs are combinational from state and instr.
REQ-020 Opcodes: 0 NOP, 1 ALU reg-reg, 2 ALU reg-imm, 4 BRA, 5 BRR, 8 LOD, 9 STR, F HLT; any other opcode is treated as NOP.
REQ-021 Transitions: START0->START1->FETCH->DECODE.
REQ-022 DECODE exits: NOP/BRA/BRR -> FETCH; HLT -> HALT; all others -> EXECUTE.
REQ-023 EXECUTE exits: ALU -> WRITEBACK; LOD/STR -> MEM.
REQ-024 MEM exits: LOD -> WRITEBACK; STR -> FETCH.
REQ-025 WRITEBACK -> FETCH; HALT holds until reset.
REQ-026 Read addresses in every state: read_rega = rs; read_regb = rd for STR, else rt. The register file latches on the DECODE->EXECUTE edge, so operands are valid in EXECUTE.
REQ-027 FETCH: ir_load=1, pc_write=1, pc_sel=0; no other enable asserted.
REQ-028 DECODE: branch taken when mm==0 or (mm & stat)!=0; if taken, pc_write=1 with pc_sel=1 (BRA) or 2 (BRR); if not taken, pc_write=0.
REQ-029 EXECUTE: alu_op=mm; alu_imm=1 for opcodes 2, 8, 9; stat_en=1 only for opcodes 1 and 2.
REQ-030 MEM: mem_we=1 for exactly one cycle, for STR only.
REQ-031 WRITEBACK: write_reg=rd, wb_sel=1 for LOD else 0; rf_we=1 unless rd==0, in which case rf_we=0.
REQ-032 Every output not named for a state is 0 in that state; write_reg=rd in all states.
REQ-033 Latency: NOP/branch 2 cycles, ALU 4, STR 4, LOD 5, all counted FETCH to next FETCH.

Reset
REQ-034 rst_f=0 at posedge clk loads START0 regardless of current state, including HALT and mid-instruction.
REQ-035 While rst_f=0, rf_we, mem_we, pc_write, ir_load and stat_en are forced to 0 combinationally, so an interrupted instruction commits nothing.
REQ-036 In START0 and START1 all outputs except read addresses and write_reg are 0; state output = START0 encoding after reset.

Structure
REQ-037 Shared package holds state encodings, opcode constants, pc_sel codes, instr field bit positions and stat bit indices.
REQ-038 One sub-module, br_cond: a combinational taken-flag from mm, stat and opcode; no other hierarchy.

Verification
REQ-039 Reset, then idle -> state START0, START1, FETCH on successive edges; all enables 0 through START1.
REQ-040 instr=32'h1532_0000, stat=0 -> EXECUTE: alu_op=5, stat_en=1; WRITEBACK: rf_we=1, write_reg=3; read_rega=2, read_regb=0 (rt).
REQ-041 instr=32'h4400_0010, stat=4'b0100 -> DECODE: pc_write=1, pc_sel=1, next FETCH; same with stat=4'b0001 -> pc_write=0.
REQ-042 instr=32'h8070_0004 (LOD) -> path EXECUTE, MEM, WRITEBACK; alu_imm=1; mem_we=0 throughout; WRITEBACK: wb_sel=1, rf_we=1, write_reg=7.
REQ-043 instr=32'h1100_0000 (rd=0) -> WRITEBACK: rf_we=0; STR 32'h9060_0002 -> MEM: mem_we=1 for one cycle, read_regb=6, rf_we never asserted.
REQ-044 rst_f=0 during WRITEBACK of an ALU op -> rf_we=0 that cycle, next state START0; HLT (32'hF000_0000) -> stays HALT for 10 cycles until rst_f=0.
